// File: rtl/vending_pkg.sv
// Shared types for the vending coin scheduler.
// State encoding, coin type codes and a pointer width helper.
package vending_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic COIN_5  = 1'b0;
  localparam logic COIN_10 = 1'b1;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/coin_slot_fifo.sv
// Per-inlet coin queue, one bit per entry.
// A push into a full queue is accepted only when a pop happens the same cycle.
module coin_slot_fifo
  import vending_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic dout,
  output logic full,
  output logic empty
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = ptr_w(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CMAX = CW'(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count == '0);
  assign full    = (count == CMAX);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Storage, pointers and occupancy, all cleared on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CW'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/vending_coin_scheduler.sv
// Round-robin coin replayer in front of a single-coin vending FSM.
// Queues inlet coins and issues spaced one-cycle coin_5/coin_10 pulses.
module vending_coin_scheduler
  import vending_pkg::*;
#(
  parameter int NUM_SLOTS  = 2,
  parameter int PEND_DEPTH = 2,
  parameter int GAP_CYCLES = 1,
  parameter int CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_SLOTS-1:0] slot_coin5,
  input  logic [NUM_SLOTS-1:0] slot_coin10,
  input  logic                 sched_en,
  input  logic                 dispense,
  output logic                 coin_5,
  output logic                 coin_10,
  output logic [NUM_SLOTS-1:0] reject,
  output logic                 busy,
  output logic [CNT_W-1:0]     vend_count
);

  localparam int SW = ptr_w(NUM_SLOTS);
  localparam int GW = ptr_w(GAP_CYCLES + 1);
  localparam int GAP_LAST_I =
    (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_LAST_I);
  localparam logic [SW-1:0] RR_INIT = SW'(NUM_SLOTS - 1);

  state_t state_q;
  state_t state_d;

  logic [SW-1:0]        rr_q;
  logic [SW-1:0]        rr_d;
  logic [GW-1:0]        gap_q;
  logic [GW-1:0]        gap_d;
  logic                 coin5_d;
  logic                 coin10_d;

  logic [NUM_SLOTS-1:0] q_full;
  logic [NUM_SLOTS-1:0] q_empty;
  logic [NUM_SLOTS-1:0] q_dout;
  logic [NUM_SLOTS-1:0] q_pop;
  logic [NUM_SLOTS-1:0] q_push;
  logic [NUM_SLOTS-1:0] both_in;
  logic [NUM_SLOTS-1:0] reject_d;

  logic                 grant_found;
  logic [SW-1:0]        grant_idx;

  // A lone coin pushes its type; coin10 high means type COIN_10.
  assign q_push  = slot_coin5 ^ slot_coin10;
  assign both_in = slot_coin5 & slot_coin10;

  // A pop in the same cycle frees room, so no reject then.
  assign reject_d = both_in | (q_push & q_full & ~q_pop);

  assign busy = (state_q != IDLE) | ~(&q_empty);

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    coin_slot_fifo #(
      .DEPTH(PEND_DEPTH)
    ) u_fifo (
      .clk  (clk),
      .reset(reset),
      .push (q_push[i]),
      .pop  (q_pop[i]),
      .din  (slot_coin10[i]),
      .dout (q_dout[i]),
      .full (q_full[i]),
      .empty(q_empty[i])
    );
  end

  // Grant the first non-empty slot after the last one served.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NUM_SLOTS; k++) begin
      idx = (int'(rr_q) + k) % NUM_SLOTS;
      if (!grant_found && !q_empty[idx]) begin
        grant_found = 1'b1;
        grant_idx   = SW'(idx);
      end
    end
  end

  // Next state, pops and the coin pulse to register.
  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    gap_d    = gap_q;
    q_pop    = '0;
    coin5_d  = 1'b0;
    coin10_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (sched_en && grant_found) begin
          q_pop[grant_idx] = 1'b1;
          if (q_dout[grant_idx] == COIN_10) begin
            coin10_d = 1'b1;
          end else begin
            coin5_d = 1'b1;
          end
          rr_d    = grant_idx;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        gap_d   = '0;
        state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Scheduler state and registered pulse outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rr_q    <= RR_INIT;
      gap_q   <= '0;
      coin_5  <= 1'b0;
      coin_10 <= 1'b0;
      reject  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gap_q   <= gap_d;
      coin_5  <= coin5_d;
      coin_10 <= coin10_d;
      reject  <= reject_d;
    end
  end

  // Dispense pulses counted in every state; wraps naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vend_count <= '0;
    end else if (dispense) begin
      vend_count <= vend_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_vending_coin_scheduler.sv
// Directed bench for vending_coin_scheduler.
// Checks are immediate assertions against hand-computed values.
module tb_vending_coin_scheduler;

  logic       clk;
  logic       reset;
  logic [1:0] slot_coin5;
  logic [1:0] slot_coin10;
  logic       sched_en;
  logic       dispense;
  logic       coin_5;
  logic       coin_10;
  logic [1:0] reject;
  logic       busy;
  logic [7:0] vend_count;

  int n_cmp;
  int n_bad;
  int tot5;
  int tot10;
  int both_cnt;
  int s5;
  int s10;

  vending_coin_scheduler #(
    .NUM_SLOTS (2),
    .PEND_DEPTH(2),
    .GAP_CYCLES(1),
    .CNT_W     (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .slot_coin5 (slot_coin5),
    .slot_coin10(slot_coin10),
    .sched_en   (sched_en),
    .dispense   (dispense),
    .coin_5     (coin_5),
    .coin_10    (coin_10),
    .reject     (reject),
    .busy       (busy),
    .vend_count (vend_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse tally, sampled away from the active edge.
  always @(negedge clk) begin
    if (coin_5 === 1'b1) tot5 = tot5 + 1;
    if (coin_10 === 1'b1) tot10 = tot10 + 1;
    if (coin_5 === 1'b1 && coin_10 === 1'b1)
      both_cnt = both_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    assert (obs === exp) else begin
      n_bad = n_bad + 1;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    slot_coin5  = '0;
    slot_coin10 = '0;
    dispense    = 1'b0;
    reset       = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    tot5 = 0; tot10 = 0; both_cnt = 0;
    reset = 1'b1;
    slot_coin5 = '0; slot_coin10 = '0;
    sched_en = 1'b1; dispense = 1'b0;

    // 1: reset values, then a quiet idle stretch
    #1 reset = 1'b0;
    #2;
    chk("t1_rst_c5", 32'(coin_5), 0);
    chk("t1_rst_c10", 32'(coin_10), 0);
    chk("t1_rst_rej", 32'(reject), 0);
    chk("t1_rst_busy", 32'(busy), 0);
    chk("t1_rst_vend", 32'(vend_count), 0);
    tick();
    reset = 1'b1;
    s5 = tot5; s10 = tot10;
    repeat (20) tick();
    chk("t1_quiet", 32'(tot5 + tot10 - s5 - s10), 0);
    chk("t1_busy", 32'(busy), 0);

    // 2: two coins on slot0, spacing, dispense count and wrap
    do_reset();
    sched_en = 1'b1;
    slot_coin5 = 2'b01;
    tick();
    slot_coin5 = 2'b00;
    slot_coin10 = 2'b01;
    tick();
    slot_coin10 = 2'b00;
    chk("t2_c5_on", 32'(coin_5), 1);
    chk("t2_c10_off", 32'(coin_10), 0);
    tick();
    chk("t2_c5_drop", 32'(coin_5), 0);
    tick();
    chk("t2_gap_idle", 32'(coin_5 | coin_10), 0);
    tick();
    chk("t2_c10_on", 32'(coin_10), 1);
    chk("t2_c5_off", 32'(coin_5), 0);
    tick();
    chk("t2_c10_drop", 32'(coin_10), 0);
    dispense = 1'b1;
    tick();
    dispense = 1'b0;
    chk("t2_vend1", 32'(vend_count), 1);
    tick();
    chk("t2_vend_hold", 32'(vend_count), 1);
    dispense = 1'b1;
    repeat (255) tick();
    dispense = 1'b0;
    chk("t2_vend_wrap", 32'(vend_count), 0);

    // 3: round-robin between the two slots, repeated
    do_reset();
    sched_en = 1'b1;
    for (int r = 0; r < 2; r++) begin
      slot_coin10 = 2'b01;
      slot_coin5  = 2'b10;
      tick();
      slot_coin10 = 2'b00;
      slot_coin5  = 2'b00;
      tick();
      chk("t3_s0_c10", 32'(coin_10), 1);
      chk("t3_s0_c5", 32'(coin_5), 0);
      tick();
      tick();
      chk("t3_between", 32'(coin_5 | coin_10), 0);
      tick();
      chk("t3_s1_c5", 32'(coin_5), 1);
      chk("t3_s1_c10", 32'(coin_10), 0);
      tick();
      tick();
      chk("t3_idle", 32'(busy), 0);
    end

    // 4: grants blocked, overflow reject, then drain
    do_reset();
    sched_en = 1'b0;
    slot_coin5 = 2'b01;
    tick();
    chk("t4_rej_a", 32'(reject), 0);
    tick();
    chk("t4_rej_b", 32'(reject), 0);
    tick();
    slot_coin5 = 2'b00;
    chk("t4_rej_full", 32'(reject), 32'h1);
    tick();
    chk("t4_rej_clr", 32'(reject), 0);
    chk("t4_busy", 32'(busy), 1);
    chk("t4_blocked", 32'(coin_5), 0);
    s5 = tot5;
    sched_en = 1'b1;
    tick();
    chk("t4_p1", 32'(coin_5), 1);
    tick();
    chk("t4_p1_drop", 32'(coin_5), 0);
    tick();
    tick();
    chk("t4_p2", 32'(coin_5), 1);
    tick();
    tick();
    chk("t4_busy_end", 32'(busy), 0);
    chk("t4_count", 32'(tot5 - s5), 2);

    // 5: both coin inputs on one inlet
    do_reset();
    sched_en = 1'b1;
    s5 = tot5; s10 = tot10;
    slot_coin5  = 2'b10;
    slot_coin10 = 2'b10;
    tick();
    slot_coin5  = 2'b00;
    slot_coin10 = 2'b00;
    chk("t5_rej", 32'(reject), 32'h2);
    chk("t5_busy", 32'(busy), 0);
    tick();
    chk("t5_rej_clr", 32'(reject), 0);
    repeat (4) tick();
    chk("t5_no_pulse", 32'(tot5 + tot10 - s5 - s10), 0);

    // 6: reset during an issued coin_10
    do_reset();
    sched_en = 1'b1;
    dispense = 1'b1;
    tick();
    dispense = 1'b0;
    slot_coin10 = 2'b01;
    tick();
    slot_coin10 = 2'b00;
    tick();
    chk("t6_c10_on", 32'(coin_10), 1);
    #2 reset = 1'b0;
    #1;
    chk("t6_c10_drop", 32'(coin_10), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_vend_rst", 32'(vend_count), 0);
    tick();
    reset = 1'b1;
    s5 = tot5; s10 = tot10;
    repeat (10) tick();
    chk("t6_quiet", 32'(tot5 + tot10 - s5 - s10), 0);
    chk("t6_vend", 32'(vend_count), 0);
    chk("t6_busy_end", 32'(busy), 0);

    chk("overlap", 32'(both_cnt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
